quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
Upstream stage for the 16-bit up/down counter (count_16). Converts raw quadrature encoder channels A/B and an index channel into the counter's Cnt_En, UpDown and Sclr controls. Synchronises and glitch-filters all three channels, decodes 4x-resolution steps, and flags illegal transitions. All outputs are registered and connect directly to the counter's same-named inputs on the same Clock.

Parameters:
FILTER_LEN, 3, consecutive stable samples required before a filtered channel changes; legal range 1..15
DIR_INV, 0, 1 swaps the decoded direction (UpDown inverted on every step)

Ports:
Clock    in   1  system clock; all state on its rising edge
Aclr     in   1  asynchronous active-high reset
A        in   1  encoder channel A, asynchronous to Clock
B        in   1  encoder channel B, asynchronous to Clock
Idx      in   1  encoder index channel, asynchronous to Clock
Idx_En   in   1  1 = rising index edge generates Sclr
Err_Clr  in   1  synchronous clear of the sticky Err flag
Cnt_En   out  1  one-cycle step strobe to counter
UpDown   out  1  step direction, 1 = up; valid when Cnt_En = 1
Sclr     out  1  one-cycle synchronous-clear strobe to counter
Err      out  1  sticky illegal-transition flag

Behaviour:
- Aclr = 1, at any time including mid-step: all registers clear immediately; Cnt_En = 0, UpDown = 1, Sclr = 0, Err = 0. Synchroniser stages, filtered levels, previous AB state = 00, and filter counters = 0.
- Synchroniser: 2-flop chain per channel (A, B, Idx).
- Filter, per channel: 4-bit counter.
  - Synced value equals filtered value: counter = 0.
  - Otherwise counter increments.
  - When counter reaches FILTER_LEN: filtered value takes the synced value and counter = 0.
  - A pulse stable for fewer than FILTER_LEN samples is rejected entirely.
- Decode: compare filtered {A,B} with registered previous state every cycle, then update the previous state.
  - Up sequence: 00->10->11->01->00.
  - Down sequence: the reverse of the up sequence.
  - Legal step: Cnt_En = 1 for exactly one cycle; UpDown = up XOR DIR_INV.
  - No change: Cnt_En = 0; UpDown holds its last value.
  - Both bits change in one cycle (00<->11, 10<->01): no Cnt_En; Err set; previous state still updated to the new value.
- Err: sticky. Set by an illegal step; cleared by Err_Clr. Illegal step and Err_Clr in the same cycle: Err = 1 (set wins).
- Index: Sclr = 1 for one cycle on a rising edge of the filtered Idx while Idx_En = 1. Falling edges, and edges with Idx_En = 0, produce nothing.
- Sclr and Cnt_En in the same cycle: both asserted as decoded; the counter resolves priority (Sclr wins there).
- Latency: the new A/B/Idx level is first sampled at edge k. The corresponding strobe is high during the cycle after edge k+FILTER_LEN+2, i.e. FILTER_LEN+3 cycles of latency. Fixed; independent of direction.
- Throughput: one step per cycle maximum, provided each level persists at least FILTER_LEN cycles. Faster encoder rates are filtered away by design.

Test Plan:
- Reset: hold Aclr 3 cycles with A = B = 1 -> Cnt_En = 0, UpDown = 1, Sclr = 0, Err = 0. Release; A/B stay 11 -> exactly one Err pulse-set, no Cnt_En.
- Up steps, FILTER_LEN = 3: AB 00->10->11->01->00, 10 cycles each -> 4 Cnt_En pulses, each with UpDown = 1, each exactly 6 cycles after its sampling edge. count_16 in loop goes 0 -> 4.
- Down steps: reverse sequence from 00 -> 4 pulses with UpDown = 0. Repeat with DIR_INV = 1 -> UpDown = 1.
- Glitch rejection: A high for 2 cycles, then low -> no Cnt_En. A high for 3 cycles -> one Cnt_En.
- Illegal transition: AB 00->11 in one clock -> Err = 1, Cnt_En stays 0. Err_Clr for 1 cycle -> Err = 0. Err_Clr coincident with a new illegal step -> Err remains 1.
- Index: Idx_En = 1, Idx rises for 8 cycles -> one Sclr pulse at latency 6. Idx_En = 0 -> none. Index edge coincident with an A step -> Sclr and Cnt_En both high; count_16 Q = 0. Aclr asserted mid-filter -> outputs clear in the same cycle, and no pending strobe after release.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters A/B/Idx, decodes 4x steps
// into registered Cnt_En/UpDown/Sclr strobes for count_16, and flags illegal AB jumps.
module quad_decoder #(
   parameter int unsigned FILTER_LEN = 3,
   parameter bit          DIR_INV    = 1'b0
) (
   input  logic Clock,
   input  logic Aclr,
   input  logic A,
   input  logic B,
   input  logic Idx,
   input  logic Idx_En,
   input  logic Err_Clr,
   output logic Cnt_En,
   output logic UpDown,
   output logic Sclr,
   output logic Err
);

   localparam logic [3:0] LP_FLEN = 4'(FILTER_LEN);

   // Channel bit order throughout: [2] = A, [1] = B, [0] = Idx
   logic [2:0]      w_raw;
   logic [2:0]      r_sync1;
   logic [2:0]      r_sync2;
   logic [2:0]      r_filt;
   logic [2:0]      w_filt_d;
   logic [2:0][3:0] r_cnt;
   logic [2:0][3:0] w_cnt_d;

   logic [1:0] w_ab;
   logic [1:0] r_prev_ab;
   logic       r_prev_idx;

   logic w_step;
   logic w_up;
   logic w_illegal;
   logic w_idx_rise;

   logic r_cnt_en;
   logic r_updown;
   logic r_sclr;
   logic r_err;

   assign w_raw = {A, B, Idx};
   assign w_ab  = r_filt[2:1];

   // A channel only moves after FILTER_LEN consecutive disagreeing samples
   always_comb begin
      w_filt_d = r_filt;
      w_cnt_d  = '0;
      for (int i = 0; i < 3; i++) begin
         if (r_sync2[i] != r_filt[i]) begin
            if (r_cnt[i] + 4'd1 >= LP_FLEN) begin
               w_filt_d[i] = r_sync2[i];
            end else begin
               w_cnt_d[i] = r_cnt[i] + 4'd1;
            end
         end
      end
   end

   // Up order of {A,B} is 00 -> 10 -> 11 -> 01 -> 00
   always_comb begin
      w_step    = 1'b0;
      w_up      = 1'b0;
      w_illegal = 1'b0;
      case ({r_prev_ab, w_ab})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
            w_step = 1'b1;
            w_up   = 1'b1;
         end
         4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: begin
            w_step = 1'b1;
            w_up   = 1'b0;
         end
         4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: begin
            w_illegal = 1'b1;
         end
         default: begin
            w_step    = 1'b0;
            w_illegal = 1'b0;
         end
      endcase
   end

   assign w_idx_rise = r_filt[0] & ~r_prev_idx & Idx_En;

   always_ff @(posedge Clock or posedge Aclr) begin
      if (Aclr) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_filt     <= '0;
         r_cnt      <= '0;
         r_prev_ab  <= 2'b00;
         r_prev_idx <= 1'b0;
         r_cnt_en   <= 1'b0;
         r_updown   <= 1'b1;
         r_sclr     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_sync1    <= w_raw;
         r_sync2    <= r_sync1;
         r_filt     <= w_filt_d;
         r_cnt      <= w_cnt_d;
         r_prev_ab  <= w_ab;
         r_prev_idx <= r_filt[0];
         r_cnt_en   <= w_step;
         if (w_step) begin
            r_updown <= w_up ^ DIR_INV;
         end
         r_sclr     <= w_idx_rise;
         // Set has priority over a coincident clear
         r_err      <= w_illegal | (r_err & ~Err_Clr);
      end
   end

   assign Cnt_En = r_cnt_en;
   assign UpDown = r_updown;
   assign Sclr   = r_sclr;
   assign Err    = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus random encoder traffic, checked every
// cycle against a sample-history/Gray-position reference model (both DIR_INV settings).
module tb_quad_decoder;

   localparam int unsigned FL = 3;

   logic Clock = 1'b0;
   logic Aclr, A, B, Idx, Idx_En, Err_Clr;
   logic en0, ud0, sc0, er0;
   logic en1, ud1, sc1, er1;

   quad_decoder #(.FILTER_LEN(FL), .DIR_INV(1'b0)) u_dut (
      .Clock(Clock), .Aclr(Aclr), .A(A), .B(B), .Idx(Idx), .Idx_En(Idx_En),
      .Err_Clr(Err_Clr), .Cnt_En(en0), .UpDown(ud0), .Sclr(sc0), .Err(er0)
   );

   quad_decoder #(.FILTER_LEN(FL), .DIR_INV(1'b1)) u_dut_inv (
      .Clock(Clock), .Aclr(Aclr), .A(A), .B(B), .Idx(Idx), .Idx_En(Idx_En),
      .Err_Clr(Err_Clr), .Cnt_En(en1), .UpDown(ud1), .Sclr(sc1), .Err(er1)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: raw sample history per channel, filtered levels, Gray positions
   logic [31:0] m_hist [3];
   logic [2:0]  m_f1;
   logic [2:0]  m_f2;
   logic        m_en, m_ud0, m_ud1, m_sclr, m_err;

   function automatic int gpos(input logic a, input logic b);
      return 2 * int'(b) + int'(a ^ b);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 3; c++) m_hist[c] = '0;
      m_f1 = '0; m_f2 = '0;
      m_en = 1'b0; m_ud0 = 1'b1; m_ud1 = 1'b1; m_sclr = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step();
      logic [2:0] raw, nf;
      bit all_diff;
      int d;
      raw = {A, B, Idx};
      for (int c = 0; c < 3; c++) begin
         m_hist[c] = {m_hist[c][30:0], raw[c]};
         // Two synchroniser delays, then FILTER_LEN samples opposite the filtered level
         all_diff = 1'b1;
         for (int j = 2; j <= int'(FL) + 1; j++) if (m_hist[c][j] == m_f1[c]) all_diff = 1'b0;
         nf[c] = all_diff ? ~m_f1[c] : m_f1[c];
      end
      d = (gpos(m_f1[2], m_f1[1]) - gpos(m_f2[2], m_f2[1]) + 4) % 4;
      m_en = (d == 1) || (d == 3);
      if (m_en) begin
         m_ud0 = (d == 1);
         m_ud1 = (d == 3);
      end
      m_err  = (d == 2) || (m_err && !Err_Clr);
      m_sclr = m_f1[0] && !m_f2[0] && Idx_En;
      m_f2 = m_f1;
      m_f1 = nf;
   endtask

   task automatic check_outputs();
      check("cnt_en", en0, m_en);
      check("updown", ud0, m_ud0);
      check("sclr", sc0, m_sclr);
      check("err", er0, m_err);
      check("inv_cnt_en", en1, m_en);
      check("inv_updown", ud1, m_ud1);
      check("inv_sclr", sc1, m_sclr);
      check("inv_err", er1, m_err);
   endtask

   int n_en, n_up0, n_up1, n_sclr, n_both, cnt16;

   // One clock: model advances at the edge, outputs compared 1 ns later, returns at negedge
   task automatic tick();
      @(posedge Clock);
      if (Aclr) model_reset();
      else model_step();
      #1;
      check_outputs();
      if (en0 === 1'b1) n_en++;
      if (en0 === 1'b1 && ud0 === 1'b1) n_up0++;
      if (en1 === 1'b1 && ud1 === 1'b1) n_up1++;
      if (sc0 === 1'b1) n_sclr++;
      if (sc0 === 1'b1 && en0 === 1'b1) n_both++;
      if (sc0 === 1'b1) cnt16 = 0;
      else if (en0 === 1'b1) cnt16 = (ud0 === 1'b1) ? cnt16 + 1 : cnt16 - 1;
      @(negedge Clock);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic step_ab(input logic a, input logic b, output int lat);
      A = a; B = b; lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (en0 === 1'b1 && lat == 0) lat = i;
      end
   endtask

   int lat;
   int p, dur;

   initial begin
      Aclr = 1'b1; A = 1'b1; B = 1'b1; Idx = 1'b0; Idx_En = 1'b0; Err_Clr = 1'b0;
      model_reset();
      cnt16 = 0; n_en = 0; n_up0 = 0; n_up1 = 0; n_sclr = 0; n_both = 0;
      ticks(3);
      check("reset_updown", ud0, 1);
      check("reset_err", er0, 0);

      // Release with AB = 11: filtered AB jumps 00 -> 11
      Aclr = 1'b0; n_en = 0;
      ticks(10);
      check("release_err_set", er0, 1);
      check("release_no_step", n_en, 0);
      Err_Clr = 1'b1; tick(); Err_Clr = 1'b0;
      check("err_cleared", er0, 0);

      // Up steps from 00
      Aclr = 1'b1; A = 1'b0; B = 1'b0; tick(); tick(); Aclr = 1'b0;
      ticks(6);
      cnt16 = 0; n_en = 0; n_up0 = 0; n_up1 = 0;
      step_ab(1, 0, lat); check("up1_latency", lat, 6);
      step_ab(1, 1, lat); check("up2_latency", lat, 6);
      step_ab(0, 1, lat); check("up3_latency", lat, 6);
      step_ab(0, 0, lat); check("up4_latency", lat, 6);
      check("up_count16", cnt16, 4);
      check("up_pulses", n_up0, 4);
      check("up_inv_pulses", n_up1, 0);

      // Down steps from 00
      n_en = 0; n_up0 = 0; n_up1 = 0;
      step_ab(0, 1, lat); check("dn1_latency", lat, 6);
      step_ab(1, 1, lat); check("dn2_latency", lat, 6);
      step_ab(1, 0, lat); check("dn3_latency", lat, 6);
      step_ab(0, 0, lat); check("dn4_latency", lat, 6);
      check("dn_count16", cnt16, 0);
      check("dn_pulses", n_en, 4);
      check("dn_up_pulses", n_up0, 0);
      check("dn_inv_up_pulses", n_up1, 4);

      // Glitch rejection
      n_en = 0;
      A = 1'b1; ticks(2); A = 1'b0; ticks(10);
      check("glitch_2cyc", n_en, 0);
      A = 1'b1; ticks(3); A = 1'b0; ticks(5);
      check("pulse_3cyc", n_en, 1);
      ticks(10);

      // Illegal transitions and Err_Clr priority
      n_en = 0;
      A = 1'b1; B = 1'b1; ticks(10);
      check("illegal_err", er0, 1);
      check("illegal_no_step", n_en, 0);
      Err_Clr = 1'b1; tick(); Err_Clr = 1'b0;
      check("illegal_err_clr", er0, 0);
      A = 1'b0; B = 1'b0; ticks(5);
      Err_Clr = 1'b1; tick(); Err_Clr = 1'b0;
      check("err_set_wins", er0, 1);
      ticks(5);

      // Index
      Idx_En = 1'b1; n_sclr = 0; Idx = 1'b1; lat = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (sc0 === 1'b1 && lat == 0) lat = i;
      end
      Idx = 1'b0; ticks(10);
      check("idx_latency", lat, 6);
      check("idx_pulses", n_sclr, 1);
      Idx_En = 1'b0; n_sclr = 0; Idx = 1'b1; ticks(8); Idx = 1'b0; ticks(10);
      check("idx_disabled", n_sclr, 0);

      // Index edge coincident with an A step
      Idx_En = 1'b1; n_both = 0; cnt16 = 7;
      Idx = 1'b1; A = 1'b1; ticks(10);
      check("idx_step_both", n_both, 1);
      check("idx_step_count16", cnt16, 0);
      Idx = 1'b0; A = 1'b0; ticks(10);

      // Aclr in the middle of a filter window
      A = 1'b1; B = 1'b1; ticks(10);
      A = 1'b0; ticks(3);
      Aclr = 1'b1; B = 1'b0;
      model_reset();
      #1;
      check("aclr_cnt_en", en0, 0);
      check("aclr_updown", ud0, 1);
      check("aclr_sclr", sc0, 0);
      check("aclr_err", er0, 0);
      check_outputs();
      ticks(2);
      Aclr = 1'b0; n_en = 0;
      ticks(15);
      check("aclr_no_pending", n_en, 0);

      // Random traffic
      p = 0;
      for (int seg = 0; seg < 120; seg++) begin
         case ($urandom_range(0, 5))
            0, 1: p = (p + 1) % 4;
            2, 3: p = (p + 3) % 4;
            4:    p = (p + 2) % 4;
            default: p = p;
         endcase
         A = (p == 1 || p == 2);
         B = (p >= 2);
         if ($urandom_range(0, 3) == 0) Idx = ~Idx;
         Idx_En = 1'($urandom_range(0, 1));
         dur = $urandom_range(1, 12);
         for (int k = 0; k < dur; k++) begin
            Err_Clr = ($urandom_range(0, 7) == 0);
            tick();
         end
      end
      Err_Clr = 1'b0;
      ticks(10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
